// File: rtl/chunk_adder_pkg.sv
// ---------------------------------------------------------------------------
// chunk_adder_pkg
// Shared types and helpers for the chunked sequential adder/subtractor.
//   state_e  : FSM state encoding (IDLE, RUN, DONE)
//   clog2    : counter width helper, never returns less than 1
//   cfg_ok   : parameter legality test used at elaboration time
// ---------------------------------------------------------------------------
package chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width needed to count 0..n-1; a 1-chunk configuration still gets a 1-bit
  // counter so no zero-width vectors appear.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder_seq_chunk_add.sv
// ---------------------------------------------------------------------------
// chunk_add
// Combinational CHUNK-bit ripple adder slice.
//   x, y   : CHUNK-bit addends
//   ci     : carry in
//   sum    : CHUNK-bit sum
//   co     : carry out of the slice MSB
//   c_msb  : carry into the slice MSB (for signed-overflow detection)
// ---------------------------------------------------------------------------
module chunk_add
  import chunk_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] total;

  assign total = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  assign sum   = total[CHUNK-1:0];
  assign co    = total[CHUNK];
  // The MSB sum bit is x^y^carry_in, so the carry into the MSB falls out of
  // it without a second adder; this also covers CHUNK==1 (c_msb == ci).
  assign c_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/chunk_adder_seq.sv
// ---------------------------------------------------------------------------
// chunk_adder_seq
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock
// with the inter-chunk carry held in a register.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   a, b, cin, sub       : operands, carry-in (add only), 1 = a-b
//   out_valid/out_ready  : result handshake (result held in DONE)
//   s, cout, ovf         : result, carry out (sub: 1 = no borrow), signed ovf
// Latency accept->out_valid is NCHUNK cycles; initiation interval NCHUNK+2.
// ---------------------------------------------------------------------------
module chunk_adder_seq
  import chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = clog2(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunk_adder_seq: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q, out_valid_q;

  logic [CHUNK-1:0] csum;
  logic             cco, cmsb;
  logic [WIDTH-1:0] s_d, opa_d, opb_d;

  chunk_add #(.CHUNK(CHUNK)) u_add (
    .x     (opa_q[CHUNK-1:0]),
    .y     (opb_q[CHUNK-1:0]),
    .ci    (carry_q),
    .sum   (csum),
    .co    (cco),
    .c_msb (cmsb)
  );

  // Each chunk sum enters at the MSB end so that after NCHUNK shifts the
  // first (least significant) chunk has arrived at bit 0.
  if (CHUNK == WIDTH) begin : g_single
    assign s_d = csum;
  end else begin : g_multi
    assign s_d = {csum, s_q[WIDTH-1:CHUNK]};
  end

  assign opa_d = opa_q >> CHUNK;
  assign opb_d = opb_q >> CHUNK;

  // NOTE: every register here, datapath included, is reset so the result
  // outputs read 0 (never X) straight out of reset and after a mid-op abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every register sees the
      // pre-edge values of the others, so the order of statements is free.
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opa_q   <= a;
            // Subtraction is a + ~b + 1; cin is deliberately ignored then.
            opb_q   <= sub ? ~b : b;
            carry_q <= sub | cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q     <= s_d;
          opa_q   <= opa_d;
          opb_q   <= opb_d;
          carry_q <= cco;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            cout_q      <= cco;
            ovf_q       <= cmsb ^ cco;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunk_adder_seq.sv
// ---------------------------------------------------------------------------
// tb_chunk_adder_seq
// Self-checking bench for chunk_adder_seq (WIDTH=16, CHUNK=4): directed
// vector table, hand-written backpressure and reset sequences, and random
// operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_chunk_adder_seq;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] s;
  logic             cout, ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  chunk_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_s;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain WIDTH+1-bit arithmetic; signed overflow from operand
  // and result signs.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       input logic mcin, input logic msub,
                       output logic [WIDTH-1:0] ms, output logic mco, output logic mov);
    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   full;
    bop  = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bop} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mcin)};
    ms   = full[WIDTH-1:0];
    mco  = full[WIDTH];
    mov  = (ma[WIDTH-1] == bop[WIDTH-1]) && (ms[WIDTH-1] != ma[WIDTH-1]);
  endtask

  // Returns at the negedge just after the accept edge (in_valid dropped).
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tcin, input logic tsub);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", 32'(w < 20), 32'd1);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] es,
                              input logic eco, input logic eov);
    check({tag, "_s"},    32'(s),    32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(eco));
    check({tag, "_ovf"},  32'(ovf),  32'(eov));
  endtask

  vec_t vecs[6];

  initial begin
    int               lat;
    logic [WIDTH-1:0] ms, hold_s;
    logic             mco, mov, hold_co, hold_ov;
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check_result("rst", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(NCHUNK));
      check_result($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_ovf);
      release_out();
    end

    // Backpressure: DONE held 5 cycles while new operands are offered.
    start_op(16'h1111, 16'h2222, 1'b1, 1'b0);
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'(NCHUNK));
    hold_s = s; hold_co = cout; hold_ov = ovf;
    check_result("bp_first", 16'h3334, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 16'(i * 16'h0101); b = 16'hF0F0; sub = i[1];
      @(negedge clk);
      check($sformatf("bp%0d_in_ready", i),  32'(in_ready),  32'd0);
      check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
      check_result($sformatf("bp%0d_hold", i), hold_s, hold_co, hold_ov);
    end
    in_valid = 1'b0;
    release_out();
    start_op(16'h0100, 16'h00FF, 1'b0, 1'b1);
    wait_done(lat);
    check("bp_next_latency", 32'(lat), 32'(NCHUNK));
    check_result("bp_next", 16'h0001, 1'b1, 1'b0);
    release_out();

    // Reset after two RUN cycles of an op that leaves a carry pending.
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    check_result("midrst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_done(lat);
    check("postrst_latency", 32'(lat), 32'(NCHUNK));
    check_result("postrst", 16'h1000, 1'b0, 1'b0);
    release_out();

    // Random operations against the reference model, random hold in DONE.
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      if (i % 10 == 0) ra = 16'hFFFF;
      model(ra, rb, rc, rs, ms, mco, mov);
      start_op(ra, rb, rc, rs);
      wait_done(lat);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(NCHUNK));
      check_result($sformatf("rnd%0d", i), ms, mco, mov);
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) @(negedge clk);
      check_result($sformatf("rnd%0d_held", i), ms, mco, mov);
      release_out();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
